beat_writer: RTL and testbench
==============================

BEAT_WRITER -- requirements
Module: beat_writer

Interface
REQ-001 SHALL have parameter BEAT_W, default 128, meaning beat data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning Avalon byte-address width.
REQ-003 SHALL have parameter BURST_MAX, default 8, meaning maximum beats per Avalon burst and internal FIFO depth (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports start (input, 1, one-cycle transfer request) and base_addr (input, ADDR_W, transfer byte start address).
REQ-007 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_data (input, BEAT_W), s_strb (input, BEAT_W/8) and s_last (input, 1), forming the packed-beat input stream.
REQ-008 SHALL have ports avm_address (output, ADDR_W), avm_write (output, 1), avm_writedata (output, BEAT_W), avm_byteenable (output, BEAT_W/8), avm_burstcount (output, $clog2(BURST_MAX)+1) and avm_waitrequest (input, 1), forming the Avalon-MM write master.
REQ-009 SHALL have ports busy (output, 1, high in any state except IDLE) and done (output, 1, one-cycle completion pulse).

Function
REQ-010 SHALL implement a state machine with states IDLE, FILL, BURST and DONE.
REQ-011 IDLE: start SHALL latch base_addr, with the low log2(BEAT_W/8) bits forced to zero, into the address register and move to FILL. start in any other state SHALL be ignored.
REQ-012 The block SHALL buffer beats in a BURST_MAX-deep FIFO of {data, strb, last}. s_ready SHALL be 1 only in FILL or BURST while the FIFO is not full and s_last has not yet been accepted. A beat is accepted when s_valid && s_ready.
REQ-013 FILL -> BURST SHALL occur when FIFO count == BURST_MAX, or when the last beat is held in the FIFO and count > 0. On this transition burst_len SHALL be set to the FIFO count.
REQ-014 BURST: avm_write SHALL be 1, and avm_address and avm_burstcount (= burst_len) SHALL stay constant for the whole burst. avm_writedata/avm_byteenable SHALL come from the FIFO head. A beat completes and pops the FIFO on each cycle with !avm_waitrequest.
REQ-015 While avm_waitrequest is high, all avm_* outputs SHALL hold stable.
REQ-016 A push and a pop in the same cycle SHALL leave the FIFO count unchanged. Pushes during BURST are permitted.
REQ-017 After the final beat of a burst, the address SHALL advance by burst_len*(BEAT_W/8), wrapping modulo 2^ADDR_W. If the popped beat carried last, the state SHALL go to DONE; otherwise it SHALL go to FILL.
REQ-018 DONE SHALL assert done for exactly one cycle, clear the last-seen flag, and return to IDLE.
REQ-019 Latency: the first avm_write SHALL be issued no earlier than the cycle after the FILL->BURST condition holds.
REQ-020 A transfer SHALL end only via s_last. Beats presented in IDLE or DONE SHALL be refused (s_ready=0).

Reset
REQ-021 On rst, the state SHALL be IDLE, the FIFO empty, and all flags clear. s_ready, avm_write, busy and done SHALL be 0; avm_address, avm_burstcount, avm_writedata and avm_byteenable SHALL be 0.
REQ-022 rst asserted mid-burst SHALL abandon the transfer immediately: avm_write deasserts asynchronously and no further beats are written.

Configuration
REQ-023 With macro BEAT_WRITER_STATS_EN defined, the block SHALL add output beats_written (32 bits). This counter SHALL clear on start and increment on every completed Avalon beat, and SHALL hold its value after DONE.
REQ-024 Without BEAT_WRITER_STATS_EN, the beats_written port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (BEAT_W=128, BURST_MAX=4)
REQ-025 start, base_addr=0x1000, 8 beats with last on beat 8, no waitrequest -> two bursts, burstcount=4 at 0x1000 and at 0x1040, data in order, then a single done pulse.
REQ-026 start, base_addr=0x200F, 3 beats with last on beat 3 -> one burst, burstcount=3 at 0x2000, byteenable matching s_strb per beat.
REQ-027 5 beats with last on beat 5 -> bursts of 4 at A and of 1 at A+0x40; s_ready=0 after last is accepted until the next start.
REQ-028 avm_waitrequest high for 3 cycles on beat 2 of a 4-beat burst -> address, burstcount, data and byteenable held stable; the beat count is still 4.
REQ-029 start pulsed during BURST -> ignored, with address unchanged. rst asserted mid-burst -> avm_write=0 the same cycle and state IDLE. With STATS_EN, beats_written=8 after the REQ-025 transfer.

Source files
------------

// File: rtl/beat_writer.sv
// Packed-beat stream to Avalon-MM burst write master, buffered through a BURST_MAX-deep FIFO.
// Optional beats_written statistics counter is enabled by defining BEAT_WRITER_STATS_EN.
module beat_writer #(
  parameter int BEAT_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int BURST_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [BEAT_W-1:0]            s_data,
  input  logic [BEAT_W/8-1:0]          s_strb,
  input  logic                         s_last,
  output logic [ADDR_W-1:0]            avm_address,
  output logic                         avm_write,
  output logic [BEAT_W-1:0]            avm_writedata,
  output logic [BEAT_W/8-1:0]          avm_byteenable,
  output logic [$clog2(BURST_MAX):0]   avm_burstcount,
  input  logic                         avm_waitrequest,
  output logic                         busy,
  output logic                         done
`ifdef BEAT_WRITER_STATS_EN
  ,
  output logic [31:0]                  beats_written
`endif
);

  localparam int BYTES = BEAT_W / 8;
  localparam int PTR_W = $clog2(BURST_MAX);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(BURST_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  burst_len_r;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic              last_seen_r;

  logic [BEAT_W-1:0] mem_data [BURST_MAX];
  logic [BYTES-1:0]  mem_strb [BURST_MAX];
  logic              mem_last [BURST_MAX];

  logic fifo_full;
  logic push;
  logic pop;
  logic head_last;
  logic burst_end;
  logic fill_go;
  logic in_burst;

  assign in_burst  = (state_r == S_BURST);
  assign fifo_full = (count_r == FULL_CNT);
  assign s_ready   = ((state_r == S_FILL) || in_burst) && !fifo_full && !last_seen_r;
  assign push      = s_valid && s_ready;
  assign pop       = in_burst && !avm_waitrequest;
  assign head_last = mem_last[rd_ptr_r];
  assign burst_end = pop && (beat_cnt_r == (burst_len_r - CNT_W'(1)));
  // No push can coincide with fill_go (full or last already taken), so count_r is the exact burst size.
  assign fill_go   = fifo_full || (last_seen_r && (count_r != '0));

  assign busy           = (state_r != S_IDLE);
  assign done           = (state_r == S_DONE);
  assign avm_write      = in_burst;
  assign avm_address    = addr_r;
  assign avm_burstcount = burst_len_r;
  // Gated so the bus shows zeros outside a burst, including straight out of reset.
  assign avm_writedata  = in_burst ? mem_data[rd_ptr_r] : '0;
  assign avm_byteenable = in_burst ? mem_strb[rd_ptr_r] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_r] <= s_data;
      mem_strb[wr_ptr_r] <= s_strb;
      mem_last[wr_ptr_r] <= s_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      addr_r      <= '0;
      burst_len_r <= '0;
      beat_cnt_r  <= '0;
      count_r     <= '0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      last_seen_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            addr_r  <= base_addr & ALIGN_MASK;
            state_r <= S_FILL;
          end
        end
        S_FILL: begin
          if (fill_go) begin
            burst_len_r <= count_r;
            beat_cnt_r  <= '0;
            state_r     <= S_BURST;
          end
        end
        S_BURST: begin
          if (pop) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            if (burst_end) begin
              addr_r  <= addr_r + (ADDR_W'(burst_len_r) * ADDR_W'(BYTES));
              state_r <= head_last ? S_DONE : S_FILL;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase

      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);

      if (push && !pop)      count_r <= count_r + CNT_W'(1);
      else if (pop && !push) count_r <= count_r - CNT_W'(1);

      if (state_r == S_DONE)    last_seen_r <= 1'b0;
      else if (push && s_last)  last_seen_r <= 1'b1;
    end
  end

`ifdef BEAT_WRITER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_written <= '0;
    end else if ((state_r == S_IDLE) && start) begin
      beats_written <= '0;
    end else if (pop) begin
      beats_written <= beats_written + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_beat_writer.sv
// Directed bench for beat_writer (BEAT_W=128, BURST_MAX=4); honours BEAT_WRITER_STATS_EN.
module tb_beat_writer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic [15:0]  s_strb;
  logic         s_last;
  logic [31:0]  avm_address;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic [2:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic         busy;
  logic         done;
`ifdef BEAT_WRITER_STATS_EN
  logic [31:0]  beats_written;
`endif

  beat_writer #(.BEAT_W(128), .ADDR_W(32), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb), .s_last(s_last),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done)
`ifdef BEAT_WRITER_STATS_EN
    , .beats_written(beats_written)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [127:0] src_data [16];
  logic [15:0]  src_strb [16];
  logic [31:0]  exp_addr [16];
  logic [2:0]   exp_bc   [16];
  int exp_n = 0;
  int wr_n = 0;
  int done_n = 0;
  int stall_at = -1;
  int stall_left = 0;
  logic force_wait = 1'b0;
  logic expect_no_ready = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bus model: drives waitrequest, checks every presented beat against the plan.
  always @(negedge clk) begin
    if (force_wait || (stall_left > 0 && wr_n == stall_at && avm_write)) begin
      avm_waitrequest = 1'b1;
      if (!force_wait) stall_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
    if (avm_write) begin
      if (wr_n < exp_n) begin
        check("avm_address", avm_address, exp_addr[wr_n]);
        check("avm_burstcount", avm_burstcount, exp_bc[wr_n]);
        check("avm_writedata", avm_writedata, src_data[wr_n]);
        check("avm_byteenable", avm_byteenable, src_strb[wr_n]);
      end else begin
        check("extra_write", wr_n, exp_n);
      end
      if (!avm_waitrequest) wr_n++;
    end
    if (done) done_n++;
    if (expect_no_ready) check("s_ready_after_last", s_ready, 1'b0);
  end

  task automatic pulse_start(input logic [31:0] a);
    base_addr = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int n);
    int i;
    int g;
    logic acc;
    i = 0;
    g = 0;
    while (i < n && g < 300) begin
      s_valid = 1'b1;
      s_data  = src_data[i];
      s_strb  = src_strb[i];
      s_last  = (i == n - 1);
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) i++;
      g++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("src_accepted", i, n);
  endtask

  task automatic wait_idle(input int exp_beats);
    for (int k = 0; k < 300 && done_n == 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", done_n, 1);
    check("beats_written_on_bus", wr_n, exp_beats);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic new_xfer(input int t, input int n);
    for (int i = 0; i < n; i++) begin
      src_data[i] = {4{16'(t), 16'(i)}};
      src_strb[i] = 16'hFFFF;
    end
    exp_n  = n;
    wr_n   = 0;
    done_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0;
    s_valid = 1'b0; s_data = '0; s_strb = '0; s_last = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_avm_write", avm_write, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_avm_address", avm_address, 32'h0);
    check("rst_avm_burstcount", avm_burstcount, 3'd0);
    check("rst_avm_writedata", avm_writedata, 128'h0);
    check("rst_avm_byteenable", avm_byteenable, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Beats offered while idle are refused.
    s_valid = 1'b1;
    @(negedge clk);
    check("idle_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0;

    // 8 beats at 0x1000: two bursts of 4; a stray start mid-burst must not move the address.
    new_xfer(1, 8);
    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = (i < 4) ? 32'h1000 : 32'h1040;
      exp_bc[i]   = 3'd4;
    end
    pulse_start(32'h1000);
    fork
      send(8);
      begin
        for (int k = 0; k < 300 && wr_n < 2; k++) @(posedge clk);
        #1;
        pulse_start(32'h9000);
      end
    join
    wait_idle(8);
`ifdef BEAT_WRITER_STATS_EN
    check("stats_beats_written", beats_written, 32'd8);
`endif

    // Unaligned base 0x200F: one burst of 3 at 0x2000 with varied strobes.
    new_xfer(2, 3);
    src_strb[0] = 16'h00FF;
    src_strb[1] = 16'hF0F0;
    src_strb[2] = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      exp_addr[i] = 32'h2000;
      exp_bc[i]   = 3'd3;
    end
    pulse_start(32'h200F);
    send(3);
    wait_idle(3);

    // 5 beats at 0x3000: burst of 4 then burst of 1 at +0x40; input stays closed after last.
    new_xfer(3, 5);
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = (i < 4) ? 32'h3000 : 32'h3040;
      exp_bc[i]   = (i < 4) ? 3'd4 : 3'd1;
    end
    pulse_start(32'h3000);
    send(5);
    s_valid = 1'b1;
    s_data  = 128'hDEAD;
    expect_no_ready = 1'b1;
    wait_idle(5);
    expect_no_ready = 1'b0;
    s_valid = 1'b0;

    // 4-beat burst with waitrequest held for 3 cycles on beat 2.
    new_xfer(4, 4);
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = 32'h4000;
      exp_bc[i]   = 3'd4;
    end
    stall_at   = 1;
    stall_left = 3;
    pulse_start(32'h4000);
    send(4);
    wait_idle(4);
    check("stall_consumed", stall_left, 0);
    stall_at = -1;

    // Reset in the middle of a stalled burst.
    new_xfer(5, 4);
    for (int i = 0; i < 4; i++) begin
      exp_addr[i] = 32'h5000;
      exp_bc[i]   = 3'd4;
    end
    force_wait = 1'b1;
    pulse_start(32'h5000);
    send(4);
    for (int k = 0; k < 50 && !avm_write; k++) @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_write", avm_write, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_avm_write", avm_write, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_s_ready", s_ready, 1'b0);
    check("rst_mid_avm_address", avm_address, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    force_wait = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_write_after_rst", wr_n, 0);
    check("idle_after_rst_write", avm_write, 1'b0);
    check("no_done_after_rst", done_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
